// File: rtl/mc_pkg.sv
// Shared encodings for the miniRV multi-cycle control: states, opcodes, opcode classes,
// next-PC selects and write-data selects.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    OC_R, OC_I, OC_LOAD, OC_STORE, OC_BRANCH,
    OC_JAL, OC_JALR, OC_LUI, OC_AUIPC, OC_ILLEGAL
  } opclass_e;

  localparam logic [1:0] NPC_PC4     = 2'b00;
  localparam logic [1:0] NPC_PC_IMM  = 2'b01;
  localparam logic [1:0] NPC_RS1_IMM = 2'b10;

  localparam logic [2:0] WD_ALU    = 3'd0;
  localparam logic [2:0] WD_PC4    = 3'd1;
  localparam logic [2:0] WD_DRAM   = 3'd2;
  localparam logic [2:0] WD_EXT    = 3'd3;
  localparam logic [2:0] WD_PC_IMM = 3'd4;

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: inst[6:0] to opcode class plus illegal flag.
// Kept standalone so the pipelined core can reuse the same decode.
module mc_opclass
  import mc_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opclass_e   o_opclass,
  output logic       o_illegal
);

  always_comb begin
    o_opclass = OC_ILLEGAL;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_R:      o_opclass = OC_R;
      OPC_I:      o_opclass = OC_I;
      OPC_LOAD:   o_opclass = OC_LOAD;
      OPC_STORE:  o_opclass = OC_STORE;
      OPC_BRANCH: o_opclass = OC_BRANCH;
      OPC_JAL:    o_opclass = OC_JAL;
      OPC_JALR:   o_opclass = OC_JALR;
      OPC_LUI:    o_opclass = OC_LUI;
      OPC_AUIPC:  o_opclass = OC_AUIPC;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; memory stalls hold FETCH/MEM until ack or timeout trap.
// Optional MC_PERF_CNT_EN adds cycle_cnt_o/instret_o performance counters.
module mc_control #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] inst_i,
  input  logic        br_taken_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_addr_sel_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  npc_op_o,
  output logic        rf_we_o,
  output logic [2:0]  wd_sel_o,
  output logic        retire_o,
  output logic        err_o,
  output logic [2:0]  state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);
  import mc_pkg::*;

  localparam int             CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(ACK_TIMEOUT - 1);

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_cnt;
  opclass_e      w_opclass;
  logic          w_illegal;
  logic          w_unused;

  assign w_unused = ^inst_i[31:7];

  mc_opclass u_opclass (
    .i_opcode  (inst_i[6:0]),
    .o_opclass (w_opclass),
    .o_illegal (w_illegal)
  );

  // Everything is gated by rst_n_i so a reset cycle never fires a write, even mid-instruction.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_addr_sel_o = 1'b0;
    mem_we_o       = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    npc_op_o       = NPC_PC4;
    rf_we_o        = 1'b0;
    wd_sel_o       = WD_ALU;
    retire_o       = 1'b0;
    err_o          = 1'b0;
    w_next         = r_state;
    if (rst_n_i) begin
      case (r_state)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            ir_we_o = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (w_opclass)
            OC_BRANCH: begin
              pc_we_o  = 1'b1;
              npc_op_o = br_taken_i ? NPC_PC_IMM : NPC_PC4;
              retire_o = 1'b1;
              w_next   = S_FETCH;
            end
            OC_LOAD, OC_STORE: w_next = S_MEM;
            default:           w_next = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (w_opclass == OC_STORE);
          if (mem_ack_i) begin
            if (w_opclass == OC_STORE) begin
              pc_we_o  = 1'b1;
              retire_o = 1'b1;
              w_next   = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          w_next   = S_FETCH;
          case (w_opclass)
            OC_JAL:   begin wd_sel_o = WD_PC4; npc_op_o = NPC_PC_IMM;  end
            OC_JALR:  begin wd_sel_o = WD_PC4; npc_op_o = NPC_RS1_IMM; end
            OC_LOAD:  wd_sel_o = WD_DRAM;
            OC_LUI:   wd_sel_o = WD_EXT;
            OC_AUIPC: wd_sel_o = WD_PC_IMM;
            default:  wd_sel_o = WD_ALU;
          endcase
        end
        S_TRAP:  err_o  = 1'b1;
        default: w_next = S_TRAP;
      endcase
      // An ack in the final allowed cycle still wins, so only the unacked case traps.
      if (mem_req_o && !mem_ack_i && r_cnt == TO_LAST) w_next = S_TRAP;
    end
  end

  assign state_o = rst_n_i ? r_state : S_FETCH;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (mem_req_o && !mem_ack_i && w_next == r_state) r_cnt <= r_cnt + CW'(1);
      else                                               r_cnt <= '0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (retire_o)          r_instret   <= r_instret + 32'd1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign instret_o   = r_instret;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction expected cycle sequences built from the
// opcode-class rules, compared cycle by cycle against the DUT outputs.
module tb_mc_control;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] inst_i;
  logic        br_taken_i;
  logic        mem_ack_i;
  logic        mem_req_o, mem_addr_sel_o, mem_we_o, ir_we_o, pc_we_o;
  logic [1:0]  npc_op_o;
  logic        rf_we_o;
  logic [2:0]  wd_sel_o;
  logic        retire_o, err_o;
  logic [2:0]  state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instret_o;
  logic [31:0] exp_cyc = 0, exp_ret = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mc_control #(.ACK_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .inst_i         (inst_i),
    .br_taken_i     (br_taken_i),
    .mem_ack_i      (mem_ack_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .mem_we_o       (mem_we_o),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .npc_op_o       (npc_op_o),
    .rf_we_o        (rf_we_o),
    .wd_sel_o       (wd_sel_o),
    .retire_o       (retire_o),
    .err_o          (err_o),
    .state_o        (state_o)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt_o    (cycle_cnt_o),
    .instret_o      (instret_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed view {req,asel,we,ir_we,pc_we,npc[1:0],rf_we,wd[2:0],retire,err,state[2:0]}.
  function automatic logic [15:0] pk(input logic req, input logic asel, input logic we,
                                     input logic irwe, input logic pcwe, input logic [1:0] npc,
                                     input logic rfwe, input logic [2:0] wd, input logic ret,
                                     input logic err, input logic [2:0] st);
    return {req, asel, we, irwe, pcwe, npc, rfwe, wd, ret, err, st};
  endfunction

  // npc_op/wd_sel only matter alongside their enables.
  function automatic logic [15:0] obs();
    logic [1:0] n;
    logic [2:0] w;
    n = pc_we_o ? npc_op_o : 2'b00;
    w = rf_we_o ? wd_sel_o : 3'b000;
    return {mem_req_o, mem_addr_sel_o, mem_we_o, ir_we_o, pc_we_o, n, rf_we_o, w,
            retire_o, err_o, state_o};
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  // One clock: drive inputs, compare at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic [15:0] e, input logic ack, input logic br);
    mem_ack_i  = ack;
    br_taken_i = br;
    @(negedge clk_i);
    check(tag, 32'(obs()), 32'(e));
`ifdef MC_PERF_CNT_EN
    check({tag, "_cycles"}, cycle_cnt_o, exp_cyc);
    check({tag, "_instret"}, instret_o, exp_ret);
`endif
    @(posedge clk_i);
`ifdef MC_PERF_CNT_EN
    if (!rst_n_i) begin
      exp_cyc = 0;
      exp_ret = 0;
    end else begin
      if (e[2:0] != 3'd7) exp_cyc++;
      if (e[4]) exp_ret++;
    end
`endif
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    cyc("reset", 16'h0000, 1'b1, 1'($urandom));
    cyc("reset", 16'h0000, 1'($urandom), 1'($urandom));
    rst_n_i = 1'b1;
  endtask

  task automatic trap_cycles(input int n);
    for (int k = 0; k < n; k++)
      cyc("trap", pk(0,0,0,0,0,2'b00,0,3'd0,0,1,3'd7), 1'($urandom), 1'($urandom));
  endtask

  // fw/mw: wait cycles before ack in FETCH/MEM; 4 or more means never ack (timeout).
  task automatic run_instr(input logic [31:0] inst, input int fw, input int mw, input logic br);
    logic [6:0] op;
    logic       ld, st;
    logic [2:0] wd;
    logic [1:0] np;
    op = inst[6:0];
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    wd = 3'd0;
    np = 2'b00;
    case (op)
      7'b1101111: begin wd = 3'd1; np = 2'b01; end
      7'b1100111: begin wd = 3'd1; np = 2'b10; end
      7'b0000011: wd = 3'd2;
      7'b0110111: wd = 3'd3;
      7'b0010111: wd = 3'd4;
      default:    wd = 3'd0;
    endcase
    if (fw >= 4) begin
      for (int k = 0; k < 4; k++)
        cyc("fetch_wait", pk(1,0,0,0,0,2'b00,0,3'd0,0,0,3'd0), 1'b0, 1'($urandom));
      trap_cycles(3);
      do_reset();
      return;
    end
    for (int k = 0; k <= fw; k++)
      cyc("fetch", pk(1,0,0,k == fw,0,2'b00,0,3'd0,0,0,3'd0), k == fw, 1'($urandom));
    inst_i = inst;
    cyc("decode", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd1), 1'($urandom), 1'($urandom));
    if (!legal(op)) begin
      trap_cycles(3);
      do_reset();
      return;
    end
    if (op == 7'b1100011) begin
      cyc("exec_branch", pk(0,0,0,0,1,{1'b0, br},0,3'd0,1,0,3'd2), 1'($urandom), br);
      return;
    end
    cyc("exec", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd2), 1'($urandom), 1'($urandom));
    if (ld || st) begin
      if (mw >= 4) begin
        for (int k = 0; k < 4; k++)
          cyc("mem_wait", pk(1,1,st,0,0,2'b00,0,3'd0,0,0,3'd3), 1'b0, 1'($urandom));
        trap_cycles(2);
        do_reset();
        return;
      end
      for (int k = 0; k <= mw; k++)
        cyc("mem", pk(1,1,st,0,st && k == mw,2'b00,0,3'd0,st && k == mw,0,3'd3),
            k == mw, 1'($urandom));
    end
    if (!st)
      cyc("wb", pk(0,0,0,0,1,np,1,wd,1,0,3'd4), 1'($urandom), 1'($urandom));
  endtask

  // Reset lands on the MEM cycle of a store that is being acked.
  task automatic store_reset();
    cyc("sr_fetch", pk(1,0,0,1,0,2'b00,0,3'd0,0,0,3'd0), 1'b1, 1'b0);
    inst_i = 32'h0062a023;
    cyc("sr_decode", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd1), 1'b0, 1'b0);
    cyc("sr_exec", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd2), 1'b0, 1'b0);
    rst_n_i = 1'b0;
    cyc("sr_reset", 16'h0000, 1'b1, 1'b0);
    rst_n_i = 1'b1;
    cyc("sr_refetch", pk(1,0,0,1,0,2'b00,0,3'd0,0,0,3'd0), 1'b1, 1'b0);
    cyc("sr_decode2", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd1), 1'b0, 1'b0);
    cyc("sr_exec2", pk(0,0,0,0,0,2'b00,0,3'd0,0,0,3'd2), 1'b0, 1'b0);
    cyc("sr_mem2", pk(1,1,1,0,1,2'b00,0,3'd0,1,0,3'd3), 1'b1, 1'b0);
  endtask

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0]  op;
    logic [31:0] inst;
    int          fw, mw;
    rst_n_i    = 1'b0;
    inst_i     = 32'h0;
    br_taken_i = 1'b0;
    mem_ack_i  = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset();

    run_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
    run_instr(32'h0002a303, 0, 3, 1'b0);   // lw, data ack after 3 waits
    run_instr(32'h00000063, 1, 0, 1'b1);   // beq taken
    run_instr(32'h00000063, 0, 0, 1'b0);   // beq not taken
    run_instr(32'h00008067, 0, 0, 1'b0);   // jalr
    run_instr(32'h0000007f, 0, 0, 1'b0);   // illegal opcode
    run_instr(32'h00500093, 4, 0, 1'b0);   // fetch timeout
    run_instr(32'h0062a023, 0, 4, 1'b0);   // store timeout in MEM
    run_instr(32'h0062a023, 0, 3, 1'b0);   // store acked on last allowed cycle
    store_reset();

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) begin
        do op = 7'($urandom); while (legal(op));
      end
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0) fw = 4;
      if ($urandom_range(0, 29) == 0) mw = 4;
      inst = ($urandom & 32'hffff_ff80) | {25'd0, op};
      run_instr(inst, fw, mw, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
